// File: rtl/est_state_update_serial_if.sv
// ============================================================================
// Module      : est_state_update_serial_if
// Description : Request/result bundle for the serial 2x2 Kalman measurement
//               update: start handshake, gain/state/observation operands,
//               and the busy/done/updated-state results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FXP_N
`define FXP_N 16
`endif

interface est_state_update_serial_if #(
  parameter int N = `FXP_N
);
  logic         start;
  logic [N-1:0] k00;
  logic [N-1:0] k01;
  logic [N-1:0] k10;
  logic [N-1:0] k11;
  logic [N-1:0] x00;
  logic [N-1:0] x10;
  logic [N-1:0] z00;
  logic [N-1:0] z10;
  logic [N-1:0] zp00;
  logic [N-1:0] zp10;
  logic         busy;
  logic         done;
  logic [N-1:0] X00;
  logic [N-1:0] X10;

  // Requester side: issues operands and start, observes results
  modport master (
    output start, k00, k01, k10, k11, x00, x10, z00, z10, zp00, zp10,
    input  busy, done, X00, X10
  );

  // Datapath side: consumes operands, produces results
  modport slave (
    input  start, k00, k01, k10, k11, x00, x10, z00, z10, zp00, zp10,
    output busy, done, X00, X10
  );
endinterface

`default_nettype wire

// File: rtl/est_state_update_serial.sv
// ============================================================================
// Module      : est_state_update_serial
// Description : Serial 2x2 Kalman measurement update. Forms the innovation
//               r = z - zp, then X = x + K*r, one state row at a time, using
//               two shared full-width multipliers and one 2N-bit adder over a
//               six-cycle schedule (IDLE, RES, L0, C0, L1, C1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module est_state_update_serial #(
  parameter int N    = `FXP_N,
  parameter int FRAC = `FXP_FRAC
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  est_state_update_serial_if.slave  bus
);

  localparam int c_LANES = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RES  = 3'd1,
    S_L0   = 3'd2,
    S_C0   = 3'd3,
    S_L1   = 3'd4,
    S_C1   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;

  // Operands captured on the accepting edge
  logic [N-1:0] r_k00, r_k01, r_k10, r_k11;
  logic [N-1:0] r_x00, r_x10;
  logic [N-1:0] r_z00, r_z10, r_zp00, r_zp10;

  // Innovation (residual) registers
  logic [N-1:0] r_r0, r_r1;

  // Shared multiplier operand registers, one pair per lane
  logic [N-1:0] r_mul_a [c_LANES];
  logic [N-1:0] r_mul_b [c_LANES];

  // Result registers
  logic [N-1:0] r_upd00, r_upd10;
  logic         r_done;

  // Datapath wires
  logic [2*N-1:0] w_prod [c_LANES];
  logic [2*N-1:0] w_sum;
  logic [N-1:0]   w_trunc;
  logic           w_unused_sum_bits;

  // Two shared multipliers producing full 2N-bit signed products
  generate
    for (genvar g = 0; g < c_LANES; g++) begin : g_mul
      logic [2*N-1:0] w_a_ext;
      logic [2*N-1:0] w_b_ext;
      assign w_a_ext  = {{N{r_mul_a[g][N-1]}}, r_mul_a[g]};
      assign w_b_ext  = {{N{r_mul_b[g][N-1]}}, r_mul_b[g]};
      assign w_prod[g] = w_a_ext * w_b_ext;
    end
  endgenerate

  // Dot-product sum wraps at 2N bits; the Q-format window drops FRAC LSBs
  assign w_sum             = w_prod[0] + w_prod[1];
  assign w_trunc           = w_sum[FRAC+N-1:FRAC];
  assign w_unused_sum_bits = ^{w_sum[2*N-1:FRAC+N], w_sum[FRAC-1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each working state lasts exactly one cycle
  always_comb begin
    w_state_nxt = S_IDLE;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy      = 1'b0;
        w_state_nxt = bus.start ? S_RES : S_IDLE;
      end
      S_RES:   w_state_nxt = S_L0;
      S_L0:    w_state_nxt = S_C0;
      S_C0:    w_state_nxt = S_L1;
      S_L1:    w_state_nxt = S_C1;
      S_C1:    w_state_nxt = S_IDLE;
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, residual formation, multiplier loading and row updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k00   <= '0;
      r_k01   <= '0;
      r_k10   <= '0;
      r_k11   <= '0;
      r_x00   <= '0;
      r_x10   <= '0;
      r_z00   <= '0;
      r_z10   <= '0;
      r_zp00  <= '0;
      r_zp10  <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_upd00 <= '0;
      r_upd10 <= '0;
      for (int i = 0; i < c_LANES; i++) begin
        r_mul_a[i] <= '0;
        r_mul_b[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k00  <= bus.k00;
            r_k01  <= bus.k01;
            r_k10  <= bus.k10;
            r_k11  <= bus.k11;
            r_x00  <= bus.x00;
            r_x10  <= bus.x10;
            r_z00  <= bus.z00;
            r_z10  <= bus.z10;
            r_zp00 <= bus.zp00;
            r_zp10 <= bus.zp10;
          end
        end
        S_RES: begin
          r_r0 <= r_z00 - r_zp00;
          r_r1 <= r_z10 - r_zp10;
        end
        S_L0: begin
          r_mul_a[0] <= r_k00;
          r_mul_b[0] <= r_r0;
          r_mul_a[1] <= r_k01;
          r_mul_b[1] <= r_r1;
        end
        S_C0: begin
          r_upd00 <= r_x00 + w_trunc;
        end
        S_L1: begin
          r_mul_a[0] <= r_k10;
          r_mul_b[0] <= r_r0;
          r_mul_a[1] <= r_k11;
          r_mul_b[1] <= r_r1;
        end
        S_C1: begin
          r_upd10 <= r_x10 + w_trunc;
        end
        default: begin
        end
      endcase
    end
  end

  // Completion pulse in the cycle following the final capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_C1);
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.X00  = r_upd00;
  assign bus.X10  = r_upd10;

endmodule

`default_nettype wire

// File: tb/tb_est_state_update_serial.sv
// ============================================================================
// Module      : tb_est_state_update_serial
// Description : Self-checking bench for est_state_update_serial (Q8.8).
//               Vector table plus hand-written multi-cycle sequences; expected
//               results are queued when an operation is started and checked
//               when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_est_state_update_serial;

  localparam int N    = 16;
  localparam int FRAC = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  est_state_update_serial_if #(.N(N)) bus ();

  est_state_update_serial #(.N(N), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] k00, k01, k10, k11;
    logic [15:0] x00, x10;
    logic [15:0] z00, z10, zp00, zp10;
    logic [15:0] e00, e10;
  } vec_t;

  typedef struct {
    logic [15:0] e00;
    logic [15:0] e10;
    int          id;
  } exp_t;

  localparam int c_NVEC = 6;
  vec_t vecs [c_NVEC];
  exp_t sb [$];
  exp_t e_mon;

  int ncmp     = 0;
  int nfail    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
      end else begin
        e_mon = sb.pop_front();
        check($sformatf("X00[%0d]", e_mon.id), {16'h0, bus.X00}, {16'h0, e_mon.e00});
        check($sformatf("X10[%0d]", e_mon.id), {16'h0, bus.X10}, {16'h0, e_mon.e10});
      end
    end
  end

  // Reference row: x + trunc(ka*ra + kb*rb), all two's-complement wrap
  function automatic logic [15:0] model_row(input logic [15:0] x, input logic [15:0] ka,
                                            input logic [15:0] kb, input logic [15:0] ra,
                                            input logic [15:0] rb);
    int pa, pb;
    logic [31:0] s;
    pa = int'($signed(ka)) * int'($signed(ra));
    pb = int'($signed(kb)) * int'($signed(rb));
    s  = 32'(pa + pb);
    return x + s[23:8];
  endfunction

  task automatic drive(input vec_t v);
    bus.k00  = v.k00;
    bus.k01  = v.k01;
    bus.k10  = v.k10;
    bus.k11  = v.k11;
    bus.x00  = v.x00;
    bus.x10  = v.x10;
    bus.z00  = v.z00;
    bus.z10  = v.z10;
    bus.zp00 = v.zp00;
    bus.zp10 = v.zp10;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [15:0] r0, r1;
    v.k00  = 16'($urandom); v.k01  = 16'($urandom);
    v.k10  = 16'($urandom); v.k11  = 16'($urandom);
    v.x00  = 16'($urandom); v.x10  = 16'($urandom);
    v.z00  = 16'($urandom); v.z10  = 16'($urandom);
    v.zp00 = 16'($urandom); v.zp10 = 16'($urandom);
    r0 = v.z00 - v.zp00;
    r1 = v.z10 - v.zp10;
    v.e00 = model_row(v.x00, v.k00, v.k01, r0, r1);
    v.e10 = model_row(v.x10, v.k10, v.k11, r0, r1);
    return v;
  endfunction

  // Start one operation (called away from the clock edge); returns in the done cycle
  task automatic do_op(input vec_t v, input int id, input bit timing);
    int   lat;
    int   bcnt;
    exp_t e;
    drive(v);
    bus.start = 1'b1;
    e.e00 = v.e00;
    e.e10 = v.e10;
    e.id  = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) bcnt++;
    end
    if (bus.done !== 1'b1) begin
      ncmp++;
      nfail++;
      $display("FAIL timeout[%0d]: got no done within %0d cycles, want done after 5", id, lat);
    end else if (timing) begin
      check($sformatf("latency[%0d]", id), 32'(lat), 32'd5);
      check($sformatf("busy_cycles[%0d]", id), 32'(bcnt), 32'd5);
    end
  endtask

  initial begin
    int   d1;
    int   dc0;
    vec_t g;

    //            k00      k01      k10      k11      x00      x10      z00      z10      zp00     zp10     e00      e10
    vecs[0] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0280, 16'h0300, 16'h0200, 16'h0280, 16'h0280, 16'h0380};
    vecs[1] = '{16'h0080, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0400, 16'hFC00, 16'h0000, 16'h0000, 16'h0200, 16'hFF00};
    vecs[2] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h8100, 16'h0000, 16'h7D00, 16'h0000};
    vecs[3] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h8100, 16'h0000};
    vecs[4] = '{16'h0100, 16'h0100, 16'h0080, 16'hFF00, 16'h0010, 16'h0020, 16'h0300, 16'h0200, 16'h0100, 16'h0100, 16'h0310, 16'h0020};
    vecs[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0180, 16'h0100, 16'h1000, 16'hFFFF, 16'h0101, 16'h0000, 16'h0001, 16'h00FF, 16'h1180};

    // Reset with start held high: reset must dominate
    rst       = 1'b1;
    bus.start = 1'b1;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_X00", {16'h0, bus.X00}, 32'h0);
    check("rst_X10", {16'h0, bus.X10}, 32'h0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    // Table: first with timing checks, remainder issued back-to-back
    do_op(vecs[0], 0, 1'b1);
    for (int i = 1; i < c_NVEC; i++) begin
      do_op(vecs[i], i, 1'b0);
    end

    // Back-to-back: start in the done cycle, next done exactly 6 cycles later
    d1 = cyc;
    do_op(vecs[1], 100, 1'b0);
    check("b2b_gap", 32'(cyc - d1), 32'd6);

    // Inputs churn and start pulses every busy cycle: latched values must win
    repeat (2) @(posedge clk);
    #1;
    dc0 = done_cnt;
    drive(vecs[4]);
    bus.start = 1'b1;
    sb.push_back('{e00: vecs[4].e00, e10: vecs[4].e10, id: 101});
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      g = rand_vec();
      drive(g);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ignored_start_done_pulses", 32'(done_cnt - dc0), 32'd1);
    check("ignored_start_idle", {31'h0, bus.busy}, 32'h0);

    // Reset while in L1: row 0 already written, then everything aborts
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("X00_before_X10", {16'h0, bus.X00}, 32'h0280);
    check("X10_not_yet", {16'h0, bus.X10}, {16'h0, vecs[4].e10});
    dc0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    check("abort_X00", {16'h0, bus.X00}, 32'h0);
    check("abort_X10", {16'h0, bus.X10}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

    // Normal operation after the abort
    do_op(vecs[1], 200, 1'b1);

    // Random operands against the reference model, back-to-back
    for (int i = 0; i < 8; i++) begin
      g = rand_vec();
      do_op(g, 300 + i, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
